// File: rtl/mem_stage_dmem_if.sv
// EXE/MEM -> MEM/WB bus for the MEM stage.
// master: EXE/MEM side; drives the instruction fields and observes the stall
//   and the MEM/WB register outputs.
// slave : the MEM stage; consumes the instruction fields, drives mem_stall
//   and the MEM/WB register outputs.
interface mem_stage_dmem_if;
  // instruction fields from the EXE/MEM register
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] maluout;
  logic [31:0] mdata_b;
  logic [4:0]  mrdrt;
  logic [3:0]  MEM_ins_type;
  logic [3:0]  MEM_ins_number;
  // stall back to upstream stages
  logic        mem_stall;
  // MEM/WB register
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [3:0]  WB_ins_type;
  logic [3:0]  WB_ins_number;
  logic        misalign;

  modport master (
    output mwreg, mm2reg, mwmem, maluout, mdata_b, mrdrt, MEM_ins_type, MEM_ins_number,
    input  mem_stall, wwreg, wm2reg, wmo, walu, wrn, WB_ins_type, WB_ins_number, misalign
  );

  modport slave (
    input  mwreg, mm2reg, mwmem, maluout, mdata_b, mrdrt, MEM_ins_type, MEM_ins_number,
    output mem_stall, wwreg, wm2reg, wmo, walu, wrn, WB_ins_type, WB_ins_number, misalign
  );
endinterface

// File: rtl/mem_stage_dmem.sv
// MEM stage: data memory, multi-cycle access sequencer and MEM/WB register.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - asynchronous active-high reset (memory contents are not reset)
//   bus  - slave side of mem_stage_dmem_if: EXE/MEM instruction fields in,
//          combinational mem_stall and registered MEM/WB outputs out
// Parameters:
//   ADDR_W  - word-address bits, memory depth 2**ADDR_W words
//   MEM_LAT - cycles a load/store occupies MEM (1..8)
//
// state | meaning
// IDLE  | c == 0, no access in progress (or first cycle of a new access)
// BUSY  | c != 0, access in progress, counting toward MEM_LAT-1
module mem_stage_dmem #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_dmem_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  state_t            state;
  logic [2:0]        c;
  logic [2:0]        c_cur;
  logic              memop;
  logic              is_store;
  logic              is_load;
  logic              misal;
  logic              stall;
  logic              do_write;
  logic [ADDR_W-1:0] idx;

  // state and c are always updated together; IDLE forces a zero count
  assign c_cur    = (state == IDLE) ? 3'd0 : c;
  assign memop    = bus.mm2reg | bus.mwmem;
  // upper address bits are dropped, so addresses wrap modulo the depth
  assign idx      = bus.maluout[ADDR_W+1:2];
  assign misal    = memop & (bus.maluout[1:0] != 2'b00);
  assign stall    = memop & (c_cur < LAST);
  // load+store together is treated as a store
  assign is_store = bus.mwmem;
  assign is_load  = bus.mm2reg & ~bus.mwmem;
  assign do_write = is_store & ~stall & ~misal;

  assign bus.mem_stall = stall;

  // a reset overlapping the completing edge aborts the write
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[idx] <= bus.mdata_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      c                 <= 3'd0;
      bus.wwreg         <= 1'b0;
      bus.wm2reg        <= 1'b0;
      bus.wmo           <= 32'd0;
      bus.walu          <= 32'd0;
      bus.wrn           <= 5'd0;
      bus.WB_ins_type   <= 4'd0;
      bus.WB_ins_number <= 4'd0;
      bus.misalign      <= 1'b0;
    end else if (stall) begin
      // bubble into WB; wmo, walu, wrn hold
      state             <= BUSY;
      c                 <= c_cur + 3'd1;
      bus.wwreg         <= 1'b0;
      bus.wm2reg        <= 1'b0;
      bus.WB_ins_type   <= 4'd0;
      bus.WB_ins_number <= 4'd0;
      bus.misalign      <= 1'b0;
    end else begin
      // completing edge of a memop, or a plain single-cycle instruction
      state             <= IDLE;
      c                 <= 3'd0;
      bus.walu          <= bus.maluout;
      bus.wrn           <= bus.mrdrt;
      bus.WB_ins_type   <= bus.MEM_ins_type;
      bus.WB_ins_number <= bus.MEM_ins_number;
      bus.wm2reg        <= is_load;
      bus.wwreg         <= bus.mwreg & ~misal & ~(bus.mm2reg & bus.mwmem);
      bus.misalign      <= misal;
      // read sees the contents before any write on this edge
      bus.wmo           <= (is_load && !misal) ? mem[idx] : 32'd0;
    end
  end

endmodule
